// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Define MULDIV_MADD_EN to make MADD/MSUB accumulate into {hi,lo}.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  localparam logic [1:0] K_MUL  = 2'd0;
  localparam logic [1:0] K_DIV  = 2'd1;
`ifdef MULDIV_MADD_EN
  localparam logic [1:0] K_MADD = 2'd2;
  localparam logic [1:0] K_MSUB = 2'd3;
`endif

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [1:0]         kind_q, kind_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               divz_q, divz_d;

  logic               sgn;
  logic               last;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_r, div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
`ifdef MULDIV_MADD_EN
  logic [2*WIDTH-1:0] hilo;
  assign hilo = {hi_q, lo_q};
`endif

  assign sgn   = (op == OP_MULT) || (op == OP_DIV) || (op[2:1] == 2'b11);
  assign a_abs = (sgn && opa[WIDTH-1]) ? -opa : opa;
  assign b_abs = (sgn && opb[WIDTH-1]) ? -opb : opb;
  assign last  = (cnt_q == CNT_W'(WIDTH - 1));

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign div_r    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_r - {1'b0, a_q};

  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    kind_d  = kind_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    divz_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          unique case (op)
            OP_MTHI: begin
              hi_d   = opa;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = opa;
              done_d = 1'b1;
            end
            OP_MULT, OP_MULTU: begin
              state_d = S_MUL;
              kind_d  = K_MUL;
            end
            OP_DIV, OP_DIVU: begin
              state_d = S_DIV;
              kind_d  = K_DIV;
            end
`ifdef MULDIV_MADD_EN
            OP_MADD: begin
              state_d = S_MUL;
              kind_d  = K_MADD;
            end
            OP_MSUB: begin
              state_d = S_MUL;
              kind_d  = K_MSUB;
            end
`else
            OP_MADD, OP_MSUB: done_d = 1'b1;
`endif
            default: ;
          endcase
          if (state_d != S_IDLE) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            neg_d  = sgn && (opa[WIDTH-1] ^ opb[WIDTH-1]);
            rneg_d = sgn && opa[WIDTH-1];
            dz_d   = (opb == '0);
            if (state_d == S_MUL) begin
              a_d   = a_abs;
              acc_d = {{WIDTH{1'b0}}, b_abs};
            end else begin
              a_d   = b_abs;
              acc_d = {{WIDTH{1'b0}}, a_abs};
            end
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
          if (last) state_d = S_FIN;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          // a set borrow bit means the trial subtraction failed: restore
          acc_d = div_diff[WIDTH]
                ? {div_r[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          cnt_d = cnt_q + CNT_W'(1);
          if (last) state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!flush) begin
          done_d = 1'b1;
          if (kind_q == K_DIV) begin
            hi_d   = rem;
            lo_d   = dz_q ? {WIDTH{1'b1}} : quo;
            divz_d = dz_q;
`ifdef MULDIV_MADD_EN
          end else if (kind_q == K_MADD) begin
            {hi_d, lo_d} = hilo + prod;
          end else if (kind_q == K_MSUB) begin
            {hi_d, lo_d} = hilo - prod;
`endif
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      kind_q  <= K_MUL;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      kind_q  <= kind_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = divz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus directed literals.
// Honours MULDIV_MADD_EN the same way as the design.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .opa(opa), .opb(opb), .flush(flush), .busy(busy),
    .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // model state
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         m_busy, m_done, m_dz, p_dz;
  int           m_cnt;

  function automatic void ref_op(input logic [2:0] o,
                                 input logic [31:0] a, b, h0, l0,
                                 output logic [31:0] rh, rl,
                                 output logic rdz);
    longint sa, sb;
    logic [63:0] p, acc;
    sa  = $signed(a);
    sb  = $signed(b);
    acc = {h0, l0};
    rdz = 1'b0;
    case (o)
      3'b000: p = 64'(sa * sb);
      3'b001: p = {32'd0, a} * {32'd0, b};
      3'b010: begin
        if (b == 0) begin p = {a, 32'hFFFFFFFF}; rdz = 1'b1; end
        else p = {32'(sa % sb), 32'(sa / sb)};
      end
      3'b011: begin
        if (b == 0) begin p = {a, 32'hFFFFFFFF}; rdz = 1'b1; end
        else p = {a % b, a / b};
      end
      3'b110: p = acc + 64'(sa * sb);
      3'b111: p = acc - 64'(sa * sb);
      default: p = acc;
    endcase
    {rh, rl} = p;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_dz = 0; m_cnt = 0;
    end else begin
      m_done = 0;
      m_dz   = 0;
      if (m_cnt > 0) begin
        if (flush) begin
          m_cnt  = 0;
          m_busy = 0;
        end else begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
            m_done = 1; m_busy = 0;
          end
        end
      end else if (start && !flush) begin
        if (op == 3'b100) begin
          m_hi = opa; m_done = 1;
        end else if (op == 3'b101) begin
          m_lo = opa; m_done = 1;
`ifndef MULDIV_MADD_EN
        end else if (op[2:1] == 2'b11) begin
          m_done = 1;
`endif
        end else begin
          ref_op(op, opa, opb, m_hi, m_lo, p_hi, p_lo, p_dz);
          m_cnt  = W + 1;
          m_busy = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    checks++;
    if ({busy, done, div_zero, hi, lo} !== {m_busy, m_done, m_dz, m_hi, m_lo}) begin
      errors++;
      $display("FAIL model t=%0t: got b=%0b d=%0b z=%0b hi=%h lo=%h need b=%0b d=%0b z=%0b hi=%h lo=%h",
               $time, busy, done, div_zero, hi, lo, m_busy, m_done, m_dz, m_hi, m_lo);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h need %h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b need %0b", nm, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    if (!done) chk1("done_timeout", done, 1'b1);
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, output int lat);
    issue(o, a, b);
    wait_done(lat);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk1("idle_timeout", busy, 1'b0);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);

    // asynchronous reset in the middle of a divide
    run(3'b100, 32'h55, 32'h0, lat);
    run(3'b101, 32'h66, 32'h0, lat);
    issue(3'b010, 32'd1000, 32'd7);
    repeat (11) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_done", done, 1'b0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(3'b011, 32'd100, 32'd7, lat);
    chk("after_rst_lat", lat, 32'd33);
    chk("after_rst_lo", lo, 32'd14);
    chk("after_rst_hi", hi, 32'd2);

    run(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    chk("multu_lat", lat, 32'd33);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    @(negedge clk);
    chk1("done_one_cycle", done, 1'b0);

    run(3'b000, 32'hFFFFFFFD, 32'd5, lat);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);

    run(3'b010, 32'hFFFFFFF9, 32'd2, lat);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    run(3'b010, 32'h80000000, 32'hFFFFFFFF, lat);
    chk("divmin_lo", lo, 32'h80000000);
    chk("divmin_hi", hi, 32'h0);

    run(3'b011, 32'd7, 32'd0, lat);
    chk("dz_lat", lat, 32'd33);
    chk("dz_hi", hi, 32'd7);
    chk("dz_lo", lo, 32'hFFFFFFFF);
    chk1("dz_flag", div_zero, 1'b1);
    @(negedge clk);
    chk1("dz_flag_clear", div_zero, 1'b0);

    // start while busy is ignored
    run(3'b100, 32'h0, 32'h0, lat);
    run(3'b101, 32'h0, 32'h0, lat);
    issue(3'b011, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'b001; opa = 32'd2; opb = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("busy_start_lat", lat + 5, 32'd33);
    chk("busy_start_lo", lo, 32'd14);
    chk("busy_start_hi", hi, 32'd2);
    repeat (40) @(negedge clk);
    chk("no_second_lo", lo, 32'd14);

    // flush in flight, start in the same cycle dropped
    run(3'b100, 32'h0, 32'h0, lat);
    run(3'b101, 32'h0, 32'h0, lat);
    issue(3'b011, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 3'b101; opa = 32'h1234;
    @(negedge clk);
    flush = 1'b0;
    chk1("flush_busy", busy, 1'b0);
    chk1("flush_done", done, 1'b0);
    chk("flush_hi", hi, 32'h0);
    chk("flush_lo", lo, 32'h0);
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h1234);
    chk1("mtlo_done", done, 1'b1);
    chk1("mtlo_busy", busy, 1'b0);

`ifdef MULDIV_MADD_EN
    run(3'b100, 32'h0, 32'h0, lat);
    run(3'b101, 32'd10, 32'h0, lat);
    run(3'b110, 32'd2, 32'd3, lat);
    chk("madd_lat", lat, 32'd33);
    chk("madd_lo", lo, 32'd16);
    chk("madd_hi", hi, 32'd0);
    run(3'b111, 32'hFFFFFFFF, 32'd4, lat);
    chk("msub_lo", lo, 32'd20);
    chk("msub_hi", hi, 32'd0);
`else
    run(3'b100, 32'd5, 32'h0, lat);
    run(3'b101, 32'd9, 32'h0, lat);
    run(3'b110, 32'd2, 32'd3, lat);
    chk("madd_nop_lat", lat, 32'd0);
    chk("madd_nop_hi", hi, 32'd5);
    chk("madd_nop_lo", lo, 32'd9);
    chk1("madd_nop_busy", busy, 1'b0);
    run(3'b111, 32'd2, 32'd3, lat);
    chk("msub_nop_lo", lo, 32'd9);
`endif
    @(negedge clk);

    for (int i = 0; i < 250; i++) begin
      logic fl, st;
      int fat, sat;
      issue(3'($urandom_range(0, 7)), pick(), pick());
      fl  = ($urandom_range(0, 7) == 0);
      st  = ($urandom_range(0, 4) == 0);
      fat = $urandom_range(0, 34);
      sat = $urandom_range(0, 34);
      for (int j = 0; j < 36; j++) begin
        if (fl && j == fat) begin
          flush = 1'b1;
        end else if (st && j == sat) begin
          start = 1'b1;
          op    = 3'($urandom_range(0, 7));
          opa   = pick();
          opb   = pick();
        end
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
      end
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
